cnn_frame_sequencer: RTL and testbench

CNN_FRAME_SEQUENCER -- requirements
Module: cnn_frame_sequencer

---
 rtl/cnn_frame_sequencer.sv | 144 ++++++++++++++
 tb/tb_cnn_frame_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/cnn_frame_sequencer.sv
// cnn_frame_sequencer: streams one stored image to the conv feeder and collects the classifier result
module cnn_frame_sequencer #(
  parameter int IX          = 28,
  parameter int IY          = 28,
  parameter int I_F_BW      = 8,
  parameter int SEL_BW      = 4,
  parameter int ADDR_BW     = 14,
  parameter int PIX_GAP     = 0,
  parameter int TIMEOUT_CYC = 4096,
  parameter int CLS_BW      = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic [SEL_BW-1:0]  i_sel,
  output logic               o_mem_rd,
  output logic [ADDR_BW-1:0] o_mem_addr,
  input  logic [I_F_BW-1:0]  i_mem_data,
  output logic               o_pix_valid,
  output logic [I_F_BW-1:0]  o_pixel,
  input  logic               i_res_valid,
  input  logic [CLS_BW-1:0]  i_res_class,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_error,
  output logic [CLS_BW-1:0]  o_class
);
  localparam int XBW = IX > 1 ? $clog2(IX) : 1;
  localparam int YBW = IY > 1 ? $clog2(IY) : 1;
  localparam int GBW = PIX_GAP > 0 ? $clog2(PIX_GAP + 1) : 1;
  localparam int TBW = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [ADDR_BW-1:0] FRAME = ADDR_BW'(IX * IY);
  localparam logic [ADDR_BW-1:0] ROW = ADDR_BW'(IX);
  typedef enum logic [1:0] {IDLE, STREAM, WAIT_RES, DONE} state_t;
  state_t state_q, state_d;
  logic [SEL_BW-1:0]  sel_q, sel_d;
  logic [XBW-1:0]     x_q, x_d;
  logic [YBW-1:0]     y_q, y_d;
  logic [GBW-1:0]     gap_q, gap_d;
  logic [TBW-1:0]     tmo_q, tmo_d;
  logic               rd_q, rd_d;
  logic [ADDR_BW-1:0] addr_q, addr_d;
  logic               pv_q, pv_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [CLS_BW-1:0]  class_q, class_d;
  logic               x_end, last_px;
  assign o_mem_rd    = rd_q;
  assign o_mem_addr  = addr_q;
  assign o_pix_valid = pv_q;
  assign o_pixel     = i_mem_data;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_error     = err_q;
  assign o_class     = class_q;
  // next state: outputs are computed for the coming cycle so they can all be registered
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    x_d     = x_q;
    y_d     = y_q;
    gap_d   = gap_q;
    tmo_d   = tmo_q;
    rd_d    = 1'b0;
    class_d = class_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    x_end   = x_q == XBW'(IX - 1);
    last_px = x_end && (y_q == YBW'(IY - 1));
    case (state_q)
      IDLE: if (i_start && !i_abort) begin
        state_d = STREAM;
        sel_d   = i_sel;
        x_d     = '0;
        y_d     = '0;
        gap_d   = '0;
        rd_d    = 1'b1;
      end
      STREAM: if (i_abort) state_d = IDLE;
        else if (rd_q) begin
          if (last_px) begin
            state_d = WAIT_RES;
            tmo_d   = '0;
          end else begin
            x_d   = x_end ? '0 : x_q + 1'b1;
            y_d   = x_end ? y_q + 1'b1 : y_q;
            gap_d = GBW'(PIX_GAP);
            rd_d  = PIX_GAP == 0;
          end
        end else begin
          gap_d = gap_q - 1'b1;
          rd_d  = gap_q == GBW'(1);
        end
      WAIT_RES: if (i_abort) state_d = IDLE;
        else if (i_res_valid) begin
          state_d = DONE;
          class_d = i_res_class;
          done_d  = 1'b1;
        end else if (tmo_q == TBW'(TIMEOUT_CYC - 1)) begin
          state_d = DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else tmo_d = tmo_q + 1'b1;
      default: state_d = IDLE;
    endcase
    busy_d = state_d == STREAM || state_d == WAIT_RES;
    pv_d   = rd_q && !i_abort;
    addr_d = ADDR_BW'(sel_d) * FRAME + ADDR_BW'(y_d) * ROW + ADDR_BW'(x_d);
  end
  // state and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      gap_q   <= '0;
      tmo_q   <= '0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      pv_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      class_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      x_q     <= x_d;
      y_q     <= y_d;
      gap_q   <= gap_d;
      tmo_q   <= tmo_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      pv_q    <= pv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      class_q <= class_d;
    end
  end
endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// tb_cnn_frame_sequencer: scoreboard bench with a frame-level reference model
module tb_cnn_frame_sequencer;
  localparam int GAP = 2;
  localparam int TMO = 16;
  localparam int NPX = 28 * 28;
  logic clk, reset, i_start, i_abort, i_res_valid;
  logic [3:0] i_sel;
  logic o_mem_rd, o_pix_valid, o_busy, o_done, o_error;
  logic [13:0] o_mem_addr;
  logic [7:0] i_mem_data, o_pixel, i_res_class, o_class;
  cnn_frame_sequencer #(.PIX_GAP(GAP), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_abort(i_abort), .i_sel(i_sel),
    .o_mem_rd(o_mem_rd), .o_mem_addr(o_mem_addr), .i_mem_data(i_mem_data),
    .o_pix_valid(o_pix_valid), .o_pixel(o_pixel), .i_res_valid(i_res_valid),
    .i_res_class(i_res_class), .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
    .o_class(o_class)
  );
  typedef struct {int cyc; int addr; bit pv;} rd_t;
  typedef struct {int cyc; bit err; logic [7:0] cls;} dn_t;
  rd_t rdq[$];
  dn_t dnq[$];
  rd_t re;
  dn_t de;
  int cyc = 0, total = 0, bad = 0;
  int busy_lo = 1, busy_hi = 0;
  bit mon_en = 0, pv_due = 0, nxt_pv;
  logic [7:0] pix_exp, nxt_pix, cls_cur = 0, m_cls = 0;
  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (o_mem_rd) i_mem_data <= o_mem_addr[7:0];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d want %0d", n, cyc, a, e);
    end
  endtask
  // monitor: pops expected reads and completions as the DUT presents them
  always @(negedge clk) if (mon_en) begin
    nxt_pv = 0;
    nxt_pix = 0;
    if (o_mem_rd) begin
      if (rdq.size() == 0) chk("rd_unexpected", o_mem_rd, 0);
      else begin
        re = rdq.pop_front();
        chk("rd_cycle", cyc, re.cyc);
        chk("rd_addr", o_mem_addr, re.addr);
        nxt_pv = re.pv;
        nxt_pix = re.addr[7:0];
      end
    end
    chk("pix_valid", o_pix_valid, pv_due);
    if (pv_due) chk("pixel", o_pixel, pix_exp);
    pv_due = nxt_pv && !reset;
    pix_exp = nxt_pix;
    chk("busy", o_busy, cyc >= busy_lo && cyc <= busy_hi);
    if (o_done) begin
      if (dnq.size() == 0) chk("done_unexpected", o_done, 0);
      else begin
        de = dnq.pop_front();
        chk("done_cycle", cyc, de.cyc);
        chk("done_error", o_error, de.err);
        cls_cur = de.cls;
      end
    end else chk("error_without_done", o_error, 0);
    chk("class", o_class, cls_cur);
    if (reset) cls_cur = 0;
  end
  task automatic chk_reset_outputs();
    chk("rst_mem_rd", o_mem_rd, 0);
    chk("rst_addr", o_mem_addr, 0);
    chk("rst_pix_valid", o_pix_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_error", o_error, 0);
    chk("rst_class", o_class, 0);
  endtask
  // one inference: res_d = result delay into WAIT_RES, ab_px = abort pixel, rst_off = reset delay into WAIT_RES
  task automatic run_frame(input int sel, input int res_d, input int ab_px, input int rst_off, input int cls);
    int c, e, ab_c, rs_c, dn_c, end_c, n;
    bit err;
    @(posedge clk); #1;
    c = cyc;
    i_start = 1;
    i_sel = 4'(sel);
    i_abort = 0;
    reset = 0;
    i_res_valid = 1'($urandom_range(0, 1));
    i_res_class = 8'($urandom);
    e = c + 1 + (NPX - 1) * (GAP + 1) + 1;
    ab_c = c + 1 + ab_px * (GAP + 1);
    rs_c = e + rst_off;
    n = ab_px >= 0 ? ab_px + 1 : NPX;
    for (int p = 0; p < n; p++) rdq.push_back('{c + 1 + p * (GAP + 1), sel * NPX + p, p != ab_px});
    busy_lo = c + 1;
    if (ab_px >= 0) begin
      busy_hi = ab_c;
      end_c = ab_c;
    end else if (rst_off >= 0) begin
      busy_hi = rs_c;
      end_c = rs_c + 1;
    end else begin
      err = !(res_d >= 0 && res_d < TMO);
      dn_c = err ? e + TMO : e + res_d + 1;
      if (!err) m_cls = 8'(cls);
      dnq.push_back('{dn_c, err, m_cls});
      busy_hi = dn_c - 1;
      end_c = dn_c;
    end
    forever begin
      @(posedge clk); #1;
      i_start = 0;
      i_abort = 0;
      i_res_valid = 0;
      reset = 0;
      if (cyc == c + 1 + 37 * (GAP + 1)) begin
        i_start = 1;
        i_sel = 4'($urandom);
      end
      if (ab_px >= 0 && cyc == ab_c) begin
        i_abort = 1;
        i_start = 1;
        i_sel = 4'(sel + 1);
      end
      if (ab_px < 0 && rst_off < 0 && cyc == e + res_d) begin
        i_res_valid = 1;
        i_res_class = 8'(cls);
      end
      if (rst_off >= 0 && cyc == rs_c) reset = 1;
      if (rst_off >= 0 && cyc == rs_c + 1) begin
        m_cls = 0;
        @(negedge clk);
        chk_reset_outputs();
      end
      if (cyc == end_c) break;
    end
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    int mode, s;
    reset = 1;
    i_start = 0;
    i_abort = 0;
    i_sel = 0;
    i_res_valid = 0;
    i_res_class = 0;
    repeat (3) @(posedge clk);
    mon_en = 1;
    @(negedge clk);
    chk_reset_outputs();
    @(posedge clk); #1;
    reset = 0;
    run_frame(2, 9, -1, -1, 'h41);
    run_frame(0, -1, -1, -1, 0);
    run_frame(7, 15, -1, -1, 'h5a);
    run_frame(5, -1, 100, -1, 0);
    run_frame(3, 16, -1, -1, 'h77);
    run_frame(9, -1, -1, 4, 0);
    run_frame(11, 0, -1, -1, 'h13);
    repeat (6) begin
      mode = $urandom_range(0, 3);
      s = $urandom_range(0, 15);
      if (mode < 2) run_frame(s, $urandom_range(0, 16), -1, -1, $urandom_range(0, 255));
      else if (mode == 2) run_frame(s, -1, $urandom_range(40, NPX - 1), -1, 0);
      else run_frame(s, -1, -1, $urandom_range(0, TMO - 1), 0);
    end
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("reads_outstanding", rdq.size(), 0);
    chk("dones_outstanding", dnq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
